// File: rtl/gcd_arbiter_if.sv
// rtl/gcd_arbiter_if.sv - request/response and shared gcd-unit signals of the gcd arbiter
interface gcd_arbiter_if #(
  parameter int W    = 8,
  parameter int NREQ = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IW-1:0]     resp_id;
  logic [W-1:0]      resp_ret;
  logic              resp_err;
  logic              gcd_rst;
  logic [W-1:0]      gcd_a;
  logic [W-1:0]      gcd_b;
  logic [W-1:0]      gcd_ret;
  logic              gcd_done;

  // Arbiter side: owns the grants, the response and the gcd-unit controls.
  modport master (
    input  req_valid, req_a, req_b, resp_ready, gcd_ret, gcd_done,
    output req_ready, resp_valid, resp_id, resp_ret, resp_err, gcd_rst, gcd_a, gcd_b
  );

  modport slave (
    output req_valid, req_a, req_b, resp_ready, gcd_ret, gcd_done,
    input  req_ready, resp_valid, resp_id, resp_ret, resp_err, gcd_rst, gcd_a, gcd_b
  );
endinterface

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin arbiter sharing one gcd unit among NREQ requesters
module gcd_arbiter #(
  parameter int W       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input logic           clk,
  input logic           rst,
  gcd_arbiter_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   idx;
  logic            win_any;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    win_a, win_b;
  logic [W-1:0]    a_q, b_q;
  logic [W-1:0]    ret_q;
  logic            err_q;
  logic [IW-1:0]   id_q;
  logic [CW-1:0]   cnt;
  logic            accept, bypass, timeout;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!win_any && bus.req_valid[idx]) begin
        win_any = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!rst && state == IDLE && win_any) grant[win_id] = 1'b1;
  end

  assign win_a   = bus.req_a[win_id*W +: W];
  assign win_b   = bus.req_b[win_id*W +: W];
  assign accept  = |grant;
  assign bypass  = (win_a == '0) || (win_b == '0);
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = grant;
    bus.resp_valid = !rst && (state == RESP);
    bus.gcd_rst    = rst || (state != RUN);
    bus.gcd_a      = a_q;
    bus.gcd_b      = b_q;
    bus.resp_id    = id_q;
    bus.resp_ret   = ret_q;
    bus.resp_err   = err_q;
    case (state)
      IDLE:    if (accept) state_nx = bypass ? RESP : LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (bus.gcd_done || timeout) state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= IW'(NREQ - 1);
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= '0;
      ret_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ptr  <= win_id;
          a_q  <= win_a;
          b_q  <= win_b;
          id_q <= win_id;
          // A zero operand makes the gcd trivially the other operand.
          if (bypass) begin
            ret_q <= (win_a == '0) ? win_b : win_a;
            err_q <= 1'b0;
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          if (bus.gcd_done) begin
            ret_q <= bus.gcd_ret;
            err_q <= 1'b0;
          end else if (timeout) begin
            ret_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - scoreboard bench for gcd_arbiter with a behavioural gcd unit
module tb_gcd_arbiter;
  localparam int W       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  gcd_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Euclid gcd unit, one remainder step per cycle; stub mode never completes.
  bit stub = 1'b0;
  logic [W-1:0] gx, gy;
  logic gdone;
  always @(posedge clk) begin
    if (bus.gcd_rst) begin
      gx    <= bus.gcd_a;
      gy    <= bus.gcd_b;
      gdone <= 1'b0;
    end else if (!gdone) begin
      if (gy == '0) gdone <= 1'b1;
      else begin
        gx <= gy;
        gy <= gx % gy;
      end
    end
  end
  assign bus.gcd_done = gdone & !stub;
  assign bus.gcd_ret  = gx;

  typedef struct {
    int id;
    int ret;
    int err;
  } exp_t;

  exp_t sb[$];
  int   grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   resp_cnt = 0;
  int   run_cyc  = 0;
  int   acc_cyc  = 0;
  int   resp_cyc = 0;
  int   last_ret = 0;
  bit   saw_run  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // One clock: observe at negedge (scoreboard push/pop), update inputs 1ns after posedge.
  task automatic step();
    logic [NREQ-1:0] acc;
    int id, a, b;
    exp_t e;
    bit to;
    acc = '0;
    id  = 0;
    @(negedge clk);
    cyc++;
    if (rst) begin
      check_eq("rst_req_ready", bus.req_ready, 0);
    end else begin
      acc = bus.req_valid & bus.req_ready;
      if (bus.req_ready != '0) check_eq("grant_onehot", $onehot(acc) && (acc == bus.req_ready), 1);
      if (bus.gcd_rst == 1'b0) begin
        run_cyc++;
        saw_run = 1'b1;
      end
      if (acc != '0) begin
        for (int i = 0; i < NREQ; i++) if (acc[i]) id = i;
        a  = int'(bus.req_a[id*W +: W]);
        b  = int'(bus.req_b[id*W +: W]);
        to = stub && a != 0 && b != 0;
        e.id  = id;
        e.ret = to ? 0 : ref_gcd(a, b);
        e.err = to ? 1 : 0;
        sb.push_back(e);
        if (grant_q.size() > 0) check_eq("grant_order", id, grant_q.pop_front());
        acc_cyc = cyc;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_resp", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("resp_id", bus.resp_id, e.id);
          check_eq("resp_ret", bus.resp_ret, e.ret);
          check_eq("resp_err", bus.resp_err, e.err);
        end
        resp_cnt++;
        resp_cyc = cyc;
        last_ret = int'(bus.resp_ret);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
    bus.req_valid[i]    = 1'b1;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int target, k;
    target = resp_cnt + n;
    k      = 0;
    while (resp_cnt < target && k < budget) begin
      step();
      k++;
    end
    if (resp_cnt < target) check_eq("wait_resp_budget", resp_cnt, target);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_resp_valid"}, bus.resp_valid, 0);
    check_eq({tag, "_gcd_rst"}, bus.gcd_rst, 1);
    check_eq({tag, "_gcd_a"}, bus.gcd_a, 0);
    check_eq({tag, "_gcd_b"}, bus.gcd_b, 0);
    check_eq({tag, "_resp_id"}, bus.resp_id, 0);
    check_eq({tag, "_resp_ret"}, bus.resp_ret, 0);
    check_eq({tag, "_resp_err"}, bus.resp_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    repeat (3) step();
    check_reset_vals("reset");
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  int bt_id[3]  = '{2, 1, 3};
  int bt_a[3]   = '{0, 9, 0};
  int bt_b[3]   = '{35, 0, 0};
  int rr_a[4]   = '{12, 35, 100, 81};
  int rr_b[4]   = '{8, 21, 75, 27};

  initial begin
    logic [31:0] cap;
    int n, k;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;

    do_reset();

    set_req(0, 48, 18);
    wait_resp(1, 100);
    check_eq("single_ret", last_ret, 6);

    // All four at once from reset, then again: strict 0,1,2,3 rotation.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_q.push_back(i);
        set_req(i, rr_a[i] + r, rr_b[i]);
      end
      wait_resp(4, 400);
      check_eq("rr_all_granted", grant_q.size(), 0);
    end

    for (int t = 0; t < 3; t++) begin
      saw_run = 1'b0;
      set_req(bt_id[t], bt_a[t], bt_b[t]);
      wait_resp(1, 20);
      check_eq("bypass_latency", resp_cyc - acc_cyc, 1);
      check_eq("bypass_no_run", saw_run, 0);
    end

    // Hold off the consumer while another requester waits.
    bus.resp_ready = 1'b0;
    set_req(3, 48, 36);
    k = 0;
    while (!bus.resp_valid && k < 50) begin
      step();
      k++;
    end
    check_eq("bp_resp_seen", bus.resp_valid, 1);
    cap = {23'd0, bus.resp_id, bus.resp_ret, bus.resp_err};
    set_req(1, 14, 21);
    repeat (5) begin
      step();
      check_eq("bp_req_ready", bus.req_ready, 0);
      check_eq("bp_resp_valid", bus.resp_valid, 1);
      check_eq("bp_stable", {23'd0, bus.resp_id, bus.resp_ret, bus.resp_err}, cap);
    end
    bus.resp_ready = 1'b1;
    n = resp_cnt;
    step();
    check_eq("bp_done_first_ready", resp_cnt, n + 1);
    wait_resp(1, 100);

    // Reset while the gcd unit is running abandons the request.
    set_req(2, 255, 1);
    k = 0;
    while (bus.gcd_rst && k < 50) begin
      step();
      k++;
    end
    check_eq("run_reached", bus.gcd_rst, 0);
    if (sb.size() > 0) void'(sb.pop_back());
    rst = 1'b1;
    step();
    check_reset_vals("midrun");
    bus.req_valid = '0;
    rst = 1'b0;
    n = resp_cnt;
    repeat (3) step();
    check_eq("midrun_no_resp", resp_cnt, n);
    grant_q.push_back(0);
    grant_q.push_back(1);
    set_req(1, 7, 3);
    set_req(0, 30, 12);
    wait_resp(2, 200);
    check_eq("midrun_grants", grant_q.size(), 0);

    // gcd unit never finishes: abort after TIMEOUT RUN cycles, then recover.
    stub    = 1'b1;
    run_cyc = 0;
    set_req(1, 20, 15);
    wait_resp(1, 100);
    check_eq("timeout_run_cycles", run_cyc, TIMEOUT);
    stub = 1'b0;
    set_req(3, 14, 21);
    wait_resp(1, 100);
    check_eq("after_timeout_ret", last_ret, 7);

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter W, default 8, operand and result width.
REQ-002 Parameter NREQ, default 4, number of requesters; ID width IW = clog2(NREQ), minimum 1.
REQ-003 Parameter TIMEOUT, default 1023, maximum RUN cycles before abort.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester request pending.
REQ-007 req_ready  output  NREQ  per-requester accept, at most one bit high.
REQ-008 req_a  input  NREQ*W  packed operand a; requester i occupies bits [i*W +: W].
REQ-009 req_b  input  NREQ*W  packed operand b, same packing as req_a.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 resp_id  output  IW  index of the requester that owns the result.
REQ-013 resp_ret  output  W  gcd result.
REQ-014 resp_err  output  1  timeout abort flag.
REQ-015 gcd_rst  output  1  drives the shared gcd unit's rst; high means hold/clear.
REQ-016 gcd_a  output  W  operand a to the gcd unit.
REQ-017 gcd_b  output  W  operand b to the gcd unit.
REQ-018 gcd_ret  input  W  gcd unit result.
REQ-019 gcd_done  input  1  gcd unit completion, held high until gcd_rst.

Function
REQ-020 State machine SHALL have exactly four states: IDLE, LOAD, RUN, RESP.
REQ-021 IDLE: req_ready SHALL be combinational and one-hot to the round-robin winner among req_valid; all bits are 0 when no request is valid.
REQ-022 Round-robin: search SHALL start at ptr+1 mod NREQ; on accept, ptr SHALL become the winner index.
REQ-023 Accept (req_valid[i] & req_ready[i]) at edge T SHALL latch a, b and id.
REQ-024 After accept, next state SHALL be LOAD if a!=0 and b!=0, otherwise RESP (bypass).
REQ-025 Bypass result SHALL be: a==0 gives ret=b; b==0 gives ret=a; both 0 gives ret=0; err=0; resp_valid at T+1; gcd_rst stays high throughout.
REQ-026 LOAD: one cycle; gcd_rst=1; gcd_a/gcd_b driven from the latched operands; next state RUN.
REQ-027 RUN: gcd_rst=0; gcd_a/gcd_b held stable; cycle counter increments from 0.
REQ-028 RUN exit on gcd_done: capture gcd_ret, err=0, go to RESP.
REQ-029 RUN exit on counter reaching TIMEOUT without gcd_done: ret=0, err=1, go to RESP.
REQ-030 Simultaneous gcd_done and timeout in the same cycle: gcd_done SHALL win.
REQ-031 RESP: resp_valid=1; gcd_rst=1; resp_id/resp_ret/resp_err held stable until resp_valid & resp_ready, then next state IDLE.
REQ-032 req_ready SHALL be 0 in every state except IDLE, so at most one request is in flight.
REQ-033 Minimum accept-to-accept interval: bypass 2 cycles; gcd path 3 cycles plus RUN length.
REQ-034 Requesters SHALL hold req_valid and their operands stable until accepted; the arbiter never drops an accepted request.

Reset
REQ-035 While rst is high at an edge: state=IDLE, ptr=NREQ-1, gcd_rst=1, gcd_a=gcd_b=0, resp_valid=0, resp_id=0, resp_ret=0, resp_err=0, counter=0.
REQ-036 req_ready SHALL be forced to 0 while rst is high.
REQ-037 Reset asserted mid-operation (LOAD/RUN/RESP) SHALL abandon the in-flight request, with no response issued.

Verification
REQ-038 Single request: requester 0, a=48, b=18 -> one response with resp_id=0, resp_ret=6, resp_err=0.
REQ-039 All four valid at once after reset, distinct operands -> grants in order 0,1,2,3; re-asserting all -> next grant is 0; each resp_id matches its requester.
REQ-040 Bypass: requester 2, a=0, b=35 -> resp_valid at accept+1, resp_ret=35, resp_id=2, gcd_rst never low.
REQ-041 Backpressure: resp_ready low for 5 cycles -> resp fields stable, req_ready=0 throughout, response completes on the first cycle resp_ready is high.
REQ-042 Reset during RUN (a=255, b=1) -> next cycle all outputs at reset values, no resp_valid; a later request from requester 0 is granted first.
REQ-043 Stub gcd unit with gcd_done tied 0, TIMEOUT=15 -> resp_err=1, resp_ret=0 after 15 RUN cycles; the arbiter then returns to IDLE.
